// File: rtl/map_overlay_pkg.sv
// Shared types and default geometry for the map-screen overlay controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: overlay state enum, default map window placement/size, and the
// width of the slide-offset register.
package map_overlay_pkg;

    // Overlay life cycle. OPENING/CLOSING exist only while sliding.
    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } map_state_t;

    // Default window placement on a 640x480 raster.
    localparam int DEF_MAP_X0 = 85;
    localparam int DEF_MAP_Y0 = 10;
    localparam int DEF_MAP_W  = 470;
    localparam int DEF_MAP_H  = 460;

    // Slide offset spans 0..MAP_H, and 460 needs 9 bits.
    localparam int OFFSET_W = 9;

endpackage

// File: rtl/map_overlay_ctrl_btn_sync_edge.sv
// Synchronises a raw asynchronous button level and emits a rise pulse.
// Latency: rise is high for one cycle, two clocks after the level goes high.
// Backpressure: none; every rising edge that survives sync yields one pulse.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   btn_raw     raw button level from the pad
//   rise        one-cycle pulse on a synchronised 0->1 transition
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= btn_raw;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;

endmodule

// File: rtl/map_overlay_ctrl.sv
// Map overlay controller: raster coords -> map-local coords, open/close toggle FSM, frame-stable level number.
// Latency: map_on/map_x/map_y one cycle after pixel_x/pixel_y; state, offset and camera_y change only at frame_start.
// Backpressure: none; follows the free-running raster every cycle.
//
// Build option: define MAP_SLIDE_EN for the vertical slide animation
// (OPENING/CLOSING states, map_busy). Without it the map toggles
// CLOSED<->OPEN instantly at frame_start, offset is 0 and map_busy is 0.
//
// Ports:
//   clk, rst_n    pixel clock, asynchronous active-low reset
//   frame_start   one-cycle pulse per frame; the only time state advances
//   pixel_x/y     current raster position, pixel_valid marks active video
//   map_btn       raw asynchronous toggle button
//   camera_y_in   live level number, sampled at frame_start onto camera_y
//   map_on        current pixel is inside the visible map region
//   map_x/map_y   map-local coordinates, 0 whenever map_on is 0
//   map_busy      slide animation in progress
module map_overlay_ctrl
    import map_overlay_pkg::*;
#(
    parameter int PHY_WIDTH  = 14,
    parameter int MAP_X0     = DEF_MAP_X0,
    parameter int MAP_Y0     = DEF_MAP_Y0,
    parameter int MAP_W      = DEF_MAP_W,
    parameter int MAP_H      = DEF_MAP_H
`ifdef MAP_SLIDE_EN
    ,
    parameter int SLIDE_STEP = 23
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic [9:0]           pixel_x,
    input  logic [9:0]           pixel_y,
    input  logic                 pixel_valid,
    input  logic                 map_btn,
    input  logic [4:0]           camera_y_in,
    output logic                 map_on,
    output logic [PHY_WIDTH-1:0] map_x,
    output logic [PHY_WIDTH-1:0] map_y,
    output logic [4:0]           camera_y,
    output logic                 map_busy
);

    // Coordinate arithmetic width: covers 0..639 plus window edges.
    localparam int CW = 12;
    localparam logic [CW-1:0] X_LO  = CW'(MAP_X0);
    localparam logic [CW-1:0] X_HI  = CW'(MAP_X0 + MAP_W);
    localparam logic [CW-1:0] Y_LO  = CW'(MAP_Y0);
    localparam logic [CW-1:0] Y_END = CW'(MAP_Y0 + MAP_H);

    map_state_t          state_q;
    map_state_t          state_d;
    logic [OFFSET_W-1:0] offset_q;
    logic                pend_q;
    logic                pend_d;
    logic                btn_rise;
    logic                take;

    btn_sync_edge u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (map_btn),
        .rise    (btn_rise)
    );

    // A rise in the frame_start cycle counts as already pending, so it is
    // consumed by that same frame boundary.
    assign take = pend_q | btn_rise;

`ifdef MAP_SLIDE_EN
    localparam logic [OFFSET_W-1:0] OFF_MAX = OFFSET_W'(MAP_H);
    localparam logic [OFFSET_W-1:0] STEP    = OFFSET_W'(SLIDE_STEP);

    logic [OFFSET_W-1:0] offset_d;
    logic [OFFSET_W-1:0] off_dn;
    logic [OFFSET_W-1:0] off_up;
    logic [OFFSET_W:0]   off_sum;

    // Saturating one-frame steps towards fully open (0) / fully closed (MAP_H).
    assign off_dn  = (offset_q > STEP) ? (offset_q - STEP) : '0;
    assign off_sum = {1'b0, offset_q} + {1'b0, STEP};
    assign off_up  = (off_sum >= {1'b0, OFF_MAX}) ? OFF_MAX : off_sum[OFFSET_W-1:0];

    // Entering or reversing a slide takes the first step in the same frame,
    // continuing from wherever the offset currently is.
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        pend_d   = pend_q | btn_rise;
        if (frame_start) begin
            pend_d = 1'b0;
            case (state_q)
                CLOSED: begin
                    if (take) begin
                        offset_d = off_dn;
                        state_d  = (off_dn == '0) ? OPEN : OPENING;
                    end
                end
                OPENING: begin
                    if (take) begin
                        offset_d = off_up;
                        state_d  = (off_up == OFF_MAX) ? CLOSED : CLOSING;
                    end else begin
                        offset_d = off_dn;
                        state_d  = (off_dn == '0) ? OPEN : OPENING;
                    end
                end
                OPEN: begin
                    if (take) begin
                        offset_d = off_up;
                        state_d  = (off_up == OFF_MAX) ? CLOSED : CLOSING;
                    end
                end
                CLOSING: begin
                    if (take) begin
                        offset_d = off_dn;
                        state_d  = (off_dn == '0) ? OPEN : OPENING;
                    end else begin
                        offset_d = off_up;
                        state_d  = (off_up == OFF_MAX) ? CLOSED : CLOSING;
                    end
                end
                default: begin
                    state_d  = CLOSED;
                    offset_d = OFF_MAX;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CLOSED;
            offset_q <= OFF_MAX;
            pend_q   <= 1'b0;
            map_busy <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            pend_q   <= pend_d;
            map_busy <= (state_d == OPENING) || (state_d == CLOSING);
        end
    end
`else
    // Instant toggle: the window is either fully shown or absent.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | btn_rise;
        if (frame_start) begin
            pend_d = 1'b0;
            if (take) begin
                state_d = (state_q == OPEN) ? CLOSED : OPEN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLOSED;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    assign offset_q = '0;
    assign map_busy = 1'b0;
`endif

    // Window test. The visible band shrinks from the bottom by offset, and
    // map_y is shifted by offset so the map's bottom rows show first.
    logic [CW-1:0]        px;
    logic [CW-1:0]        py;
    logic [CW-1:0]        y_hi;
    logic                 vis;
    logic [PHY_WIDTH-1:0] map_x_d;
    logic [PHY_WIDTH-1:0] map_y_d;

    assign px   = {{(CW-10){1'b0}}, pixel_x};
    assign py   = {{(CW-10){1'b0}}, pixel_y};
    assign y_hi = Y_END - {{(CW-OFFSET_W){1'b0}}, offset_q};

    assign vis = pixel_valid && (state_q != CLOSED)
              && (px >= X_LO) && (px < X_HI)
              && (py >= Y_LO) && (py < y_hi);

    assign map_x_d = vis ? PHY_WIDTH'(px - X_LO) : '0;
    assign map_y_d = vis ? PHY_WIDTH'(py - Y_LO + {{(CW-OFFSET_W){1'b0}}, offset_q}) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_on   <= 1'b0;
            map_x    <= '0;
            map_y    <= '0;
            camera_y <= '0;
        end else begin
            map_on <= vis;
            map_x  <= map_x_d;
            map_y  <= map_y_d;
            if (frame_start) begin
                camera_y <= camera_y_in;
            end
        end
    end

endmodule

// File: tb/tb_map_overlay_ctrl.sv
// Scoreboard bench for map_overlay_ctrl: randomized raster/button/level
// stimulus, a reference model describing the overlay as a target (open or
// closed) plus a position that walks towards it each frame, and a monitor
// that compares every registered output cycle.
module tb_map_overlay_ctrl;

    localparam int X0   = 85;
    localparam int Y0   = 10;
    localparam int W    = 470;
    localparam int H    = 460;
    localparam int STEP = 23;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pixel_valid;
    logic        map_btn;
    logic [4:0]  camera_y_in;
    logic        map_on;
    logic [13:0] map_x;
    logic [13:0] map_y;
    logic [4:0]  camera_y;
    logic        map_busy;

    always #5 clk = ~clk;

    map_overlay_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_valid (pixel_valid),
        .map_btn     (map_btn),
        .camera_y_in (camera_y_in),
        .map_on      (map_on),
        .map_x       (map_x),
        .map_y       (map_y),
        .camera_y    (camera_y),
        .map_busy    (map_busy)
    );

    typedef struct packed {
        logic        on;
        logic [13:0] x;
        logic [13:0] y;
        logic        busy;
        logic [4:0]  cam;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    // Reference model: where the user wants the map, how far it is from
    // fully open (pixels hidden above the window), press bookkeeping.
    bit         m_open;
    int         m_off;
    bit         m_pend;
    logic [4:0] m_cam;
    logic [3:0] m_hist;   // driven button level, [0]=this cycle, [k]=k cycles ago
    int         btn_left;

    function automatic bit m_closed();
`ifdef MAP_SLIDE_EN
        return !m_open && (m_off == H);
`else
        return !m_open;
`endif
    endfunction

    function automatic bit m_busy();
`ifdef MAP_SLIDE_EN
        return m_open ? (m_off != 0) : (m_off != H);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_open   = 1'b0;
`ifdef MAP_SLIDE_EN
        m_off    = H;
`else
        m_off    = 0;
`endif
        m_pend   = 1'b0;
        m_cam    = '0;
        m_hist   = '0;
        btn_left = 0;
    endtask

    // One frame boundary: a consumed press flips the target, then the map
    // moves one step towards it (no-op once it has arrived).
    task automatic model_frame(input bit consume);
        if (consume) m_open = !m_open;
`ifdef MAP_SLIDE_EN
        if (m_open) m_off = (m_off > STEP) ? m_off - STEP : 0;
        else        m_off = (m_off + STEP > H) ? H : m_off + STEP;
`endif
    endtask

    task automatic drive_cycle(input bit fs, input bit force_px, input int fx, input int fy);
        int   px;
        int   py;
        int   lim;
        bit   pv;
        bit   b;
        bit   rise;
        exp_t e;
        b = (btn_left > 0);
        if (btn_left > 0) btn_left--;
        lim = Y0 + H - m_off;
        if (force_px) begin
            px = fx; py = fy; pv = 1'b1;
        end else begin
            case ($urandom_range(0, 9))
                0: px = X0 - 1;
                1: px = X0;
                2: px = X0 + W - 1;
                3: px = X0 + W;
                4: px = 200;
                default: px = $urandom_range(0, 639);
            endcase
            case ($urandom_range(0, 9))
                0: py = Y0 - 1;
                1: py = Y0;
                2: py = lim - 1;
                3: py = lim;
                4: py = Y0 + H - 1;
                default: py = $urandom_range(0, 479);
            endcase
            pv = ($urandom_range(0, 7) != 0);
        end
        frame_start = fs;
        map_btn     = b;
        pixel_x     = 10'(px);
        pixel_y     = 10'(py);
        pixel_valid = pv;
        camera_y_in = 5'($urandom_range(0, 31));

        // Two-flop synchroniser: a level driven now is seen as a rise two cycles later.
        m_hist = {m_hist[2:0], b};
        rise   = m_hist[2] && !m_hist[3];

        e.on = pv && !m_closed() && (px >= X0) && (px < X0 + W) && (py >= Y0) && (py < lim);
        e.x  = e.on ? 14'(px - X0) : 14'd0;
        e.y  = e.on ? 14'(py - Y0 + m_off) : 14'd0;
        if (fs) begin
            model_frame(m_pend || rise);
            m_pend = 1'b0;
            m_cam  = camera_y_in;
        end else begin
            m_pend = m_pend || rise;
        end
        e.busy = m_busy();
        e.cam  = m_cam;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int len, input int press_at, input int press2_at);
        for (int i = 0; i < len; i++) begin
            if (i == press_at || i == press2_at) btn_left = 3;
            drive_cycle(i == 0, 1'b0, 0, 0);
        end
    endtask

    task automatic check_reset(input string tag);
        checks++;
        if (map_on !== 1'b0 || map_x !== 14'd0 || map_y !== 14'd0) begin
            failures++;
            $display("FAIL %s_window: got on=%0d x=%0d y=%0d, want 0 0 0", tag, map_on, map_x, map_y);
        end
        checks++;
        if (camera_y !== 5'd0 || map_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_status: got camera_y=%0d busy=%0d, want 0 0", tag, camera_y, map_busy);
        end
    endtask

    // Each entry pushed in a cycle is registered by the next posedge and
    // checked at the following negedge.
    always @(posedge clk) begin
        if (mon_en && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            @(negedge clk);
            checks++;
            if (map_on !== mon_e.on || map_x !== mon_e.x || map_y !== mon_e.y) begin
                failures++;
                $display("FAIL window @%0t: got on=%0d x=%0d y=%0d, want on=%0d x=%0d y=%0d",
                         $time, map_on, map_x, map_y, mon_e.on, mon_e.x, mon_e.y);
            end
            checks++;
            if (map_busy !== mon_e.busy || camera_y !== mon_e.cam) begin
                failures++;
                $display("FAIL status @%0t: got busy=%0d camera_y=%0d, want busy=%0d camera_y=%0d",
                         $time, map_busy, camera_y, mon_e.busy, mon_e.cam);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; pixel_x = '0; pixel_y = '0;
        pixel_valid = 1'b0; map_btn = 1'b0; camera_y_in = '0;
        model_reset();
        #12;
        check_reset("por");
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Open part way (ten steps -> offset 230), then reset asynchronously.
        run_frame(8, 1, -1);
        for (int f = 0; f < 10; f++) run_frame(8, -1, -1);
        drive_cycle(1'b0, 1'b1, 200, 30);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset("mid_slide_rst");
        frame_start = 1'b0; map_btn = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        // Closed after reset: window pixels must stay dark.
        run_frame(6, -1, -1);
        drive_cycle(1'b0, 1'b1, 200, 30);

        // Full open: press, then enough frames to reach fully open.
        run_frame(8, 2, -1);
        for (int f = 0; f < 22; f++) run_frame(8, -1, -1);
        drive_cycle(1'b0, 1'b1, 85, 10);
        drive_cycle(1'b0, 1'b1, 555, 10);
        drive_cycle(1'b0, 1'b1, 554, 469);
        drive_cycle(1'b0, 1'b1, 84, 10);
        drive_cycle(1'b0, 1'b1, 85, 9);
        drive_cycle(1'b0, 1'b1, 554, 470);

        // Close, then reopen with a press whose rise coincides with frame_start.
        run_frame(8, 2, -1);
        for (int f = 0; f < 3; f++) run_frame(8, -1, -1);
        run_frame(8, 6, -1);
        for (int f = 0; f < 3; f++) run_frame(8, -1, -1);
        drive_cycle(1'b0, 1'b1, 200, 30);
        drive_cycle(1'b0, 1'b1, 200, 33);
        // Double press inside one frame is absorbed into a single toggle.
        run_frame(16, 1, 8);
        for (int f = 0; f < 4; f++) run_frame(8, -1, -1);

        // Randomized frames of varying length and press timing.
        for (int f = 0; f < 160; f++) begin
            int len;
            int p1;
            int p2;
            len = $urandom_range(6, 24);
            p1  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
            p2  = (p1 >= 0 && $urandom_range(0, 3) == 0) ? p1 + 6 : -1;
            run_frame(len, p1, p2);
        end

        @(negedge clk); #1;
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
